// File: rtl/bus_cycle_ctrl_if.sv
// Signal bundle between the CPU core, the external pins and bus_cycle_ctrl.
// The controller connects through the slave modport; the core/pad side uses master.
interface bus_cycle_ctrl_if;
  logic        cpu_req;
  logic        cpu_wr;
  logic        cpu_mem_io;
  logic [21:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        halt_req;
  logic        wake;
  logic        dma_req;
  logic        pin_wait;
  logic [7:0]  data_bus_in;
  logic [21:0] address_bus;
  logic        addr_oe;
  logic [7:0]  data_bus_out;
  logic        data_oe;
  logic        rd;
  logic        wr;
  logic        mem_io;
  logic        halt;
  logic        dma_ack;
  logic        bus_busy;
  logic        bus_err;

  modport slave (
    input  cpu_req, cpu_wr, cpu_mem_io, cpu_addr, cpu_wdata,
    input  halt_req, wake, dma_req, pin_wait, data_bus_in,
    output cpu_ack, cpu_rdata, address_bus, addr_oe, data_bus_out, data_oe,
    output rd, wr, mem_io, halt, dma_ack, bus_busy, bus_err
  );

  modport master (
    output cpu_req, cpu_wr, cpu_mem_io, cpu_addr, cpu_wdata,
    output halt_req, wake, dma_req, pin_wait, data_bus_in,
    input  cpu_ack, cpu_rdata, address_bus, addr_oe, data_bus_out, data_oe,
    input  rd, wr, mem_io, halt, dma_ack, bus_busy, bus_err
  );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// External bus cycle sequencer: setup/strobe/hold timing, DMA arbitration, halt parking.
// Optional pin_wait timeout abort is enabled by defining BUS_WAIT_TIMEOUT_EN.
module bus_cycle_ctrl #(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 2,
  parameter int HOLD_CYC     = 1,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             arst_n,
  bus_cycle_ctrl_if.slave  bus
);

  localparam int MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_B   = (HOLD_CYC > WAIT_TIMEOUT) ? HOLD_CYC : WAIT_TIMEOUT;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DMA, S_HALT} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_load;
  logic               from_halt;
  logic               abort;
  logic [21:0]        addr_l;
  logic [7:0]         wdata_l;
  logic               wr_l, mem_io_l;
  logic               ack_q;
  logic [7:0]         rdata_q;
`ifdef BUS_WAIT_TIMEOUT_EN
  logic [CNT_W-1:0]   wcnt;
  logic               err_q;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      from_halt <= 1'b0;
`ifdef BUS_WAIT_TIMEOUT_EN
      wcnt      <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state_nx != state)
        cnt <= cnt_load;
      else if (cnt != '0)
        cnt <= cnt - CNT_W'(1);
      // DMA remembers where it came from so it can hand the bus back to HALT
      if (state_nx == S_DMA && state != S_DMA)
        from_halt <= (state == S_HALT);
`ifdef BUS_WAIT_TIMEOUT_EN
      if (state_nx != state)
        wcnt <= '0;
      else if (state == S_STROBE && cnt == '0 && bus.pin_wait)
        wcnt <= wcnt + CNT_W'(1);
`endif
    end
  end

  always_comb begin
    state_nx = state;
    abort    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.dma_req)                  state_nx = S_DMA;
        else if (bus.cpu_req && !ack_q)   state_nx = S_SETUP;
        else if (bus.halt_req)            state_nx = S_HALT;
      end
      S_SETUP:  if (cnt == '0) state_nx = S_STROBE;
      S_STROBE: begin
        if (cnt == '0) begin
          if (bus.pin_wait) begin
`ifdef BUS_WAIT_TIMEOUT_EN
            if (wcnt == CNT_W'(WAIT_TIMEOUT)) begin
              abort    = 1'b1;
              state_nx = S_IDLE;
            end
`endif
          end else begin
            state_nx = (HOLD_CYC == 0) ? S_IDLE : S_HOLD;
          end
        end
      end
      S_HOLD:   if (cnt == '0) state_nx = S_IDLE;
      S_DMA:    if (!bus.dma_req) state_nx = from_halt ? S_HALT : S_IDLE;
      S_HALT: begin
        if (bus.dma_req)   state_nx = S_DMA;
        else if (bus.wake) state_nx = S_IDLE;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (state_nx)
      S_SETUP:  cnt_load = CNT_W'(SETUP_CYC - 1);
      S_STROBE: cnt_load = CNT_W'(STROBE_CYC - 1);
      S_HOLD:   cnt_load = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
      default:  cnt_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr_l   <= '0;
      wdata_l  <= '0;
      wr_l     <= 1'b0;
      mem_io_l <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef BUS_WAIT_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE && state_nx == S_SETUP) begin
        addr_l   <= bus.cpu_addr;
        wdata_l  <= bus.cpu_wdata;
        wr_l     <= bus.cpu_wr;
        mem_io_l <= bus.cpu_mem_io;
      end
      ack_q <= (state == S_STROBE || state == S_HOLD) && state_nx == S_IDLE;
      if (state == S_STROBE && state_nx != S_STROBE && !wr_l)
        rdata_q <= abort ? 8'hFF : bus.data_bus_in;
`ifdef BUS_WAIT_TIMEOUT_EN
      err_q <= abort;
`endif
    end
  end

  // All outputs decode registered state only; no input reaches a pin combinationally
  always_comb begin
    bus.address_bus  = addr_l;
    bus.data_bus_out = wdata_l;
    bus.mem_io       = mem_io_l;
    bus.cpu_ack      = ack_q;
    bus.cpu_rdata    = rdata_q;
    bus.addr_oe      = 1'b0;
    bus.data_oe      = 1'b0;
    bus.rd           = 1'b0;
    bus.wr           = 1'b0;
    bus.halt         = 1'b0;
    bus.dma_ack      = 1'b0;
    bus.bus_busy     = (state != S_IDLE);
`ifdef BUS_WAIT_TIMEOUT_EN
    bus.bus_err      = err_q;
`else
    bus.bus_err      = 1'b0;
`endif
    unique case (state)
      S_SETUP, S_HOLD: begin
        bus.addr_oe = 1'b1;
        bus.data_oe = wr_l;
      end
      S_STROBE: begin
        bus.addr_oe = 1'b1;
        bus.data_oe = wr_l;
        bus.rd      = ~wr_l;
        bus.wr      = wr_l;
      end
      S_DMA: begin
        bus.dma_ack = 1'b1;
        bus.halt    = from_halt;
      end
      S_HALT:  bus.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a cycle-count reference model.
module tb_bus_cycle_ctrl;
  localparam int S   = 1;
  localparam int STR = 2;
  localparam int H   = 1;
`ifdef BUS_WAIT_TIMEOUT_EN
  localparam int WT  = 4;
  localparam bit TO_ON = 1'b1;
`else
  localparam int WT  = 255;
  localparam bit TO_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_CPU = 1, M_DMA = 2, M_HALT = 3;

  typedef struct {
    int          mode;
    int          k;      // cycles since the CPU access was accepted (1 = first setup cycle)
    int          ext;    // pin_wait extensions taken so far
    logic        wr;
    logic        mio;
    logic [21:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
    logic        err;
    logic        ret_halt;
  } model_t;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acks   = 0;
  model_t m = '{default: 0};

  always #5 clk = ~clk;

  bus_cycle_ctrl_if bif ();

  bus_cycle_ctrl #(
    .SETUP_CYC(S), .STROBE_CYC(STR), .HOLD_CYC(H), .WAIT_TIMEOUT(WT)
  ) dut (
    .clk(clk), .arst_n(arst_n), .bus(bif)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic model_t model_next(model_t c);
    model_t n;
    int send;
    n     = c;
    n.ack = 1'b0;
    n.err = 1'b0;
    send  = S + STR + c.ext;
    case (c.mode)
      M_IDLE: begin
        if (bif.dma_req) begin
          n.mode = M_DMA; n.ret_halt = 1'b0;
        end else if (bif.cpu_req && !c.ack) begin
          n.mode = M_CPU; n.k = 1; n.ext = 0;
          n.wr = bif.cpu_wr; n.mio = bif.cpu_mem_io;
          n.addr = bif.cpu_addr; n.wdata = bif.cpu_wdata;
        end else if (bif.halt_req) begin
          n.mode = M_HALT;
        end
      end
      M_CPU: begin
        if (c.k < send) begin
          n.k = c.k + 1;
        end else if (c.k == send) begin
          if (bif.pin_wait) begin
            if (TO_ON && c.ext == WT) begin
              n.mode = M_IDLE; n.ack = 1'b1; n.err = 1'b1;
              if (!c.wr) n.rdata = 8'hFF;
            end else begin
              n.ext = c.ext + 1; n.k = c.k + 1;
            end
          end else begin
            if (!c.wr) n.rdata = bif.data_bus_in;
            if (H == 0) begin n.mode = M_IDLE; n.ack = 1'b1; end
            else n.k = c.k + 1;
          end
        end else if (c.k == send + H) begin
          n.mode = M_IDLE; n.ack = 1'b1;
        end else begin
          n.k = c.k + 1;
        end
      end
      M_DMA:  if (!bif.dma_req) n.mode = c.ret_halt ? M_HALT : M_IDLE;
      M_HALT: begin
        if (bif.dma_req) begin n.mode = M_DMA; n.ret_halt = 1'b1; end
        else if (bif.wake) n.mode = M_IDLE;
      end
      default: n.mode = M_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) m <= '{default: 0};
    else         m <= model_next(m);
  end

  task automatic compare_all();
    logic cpu, strobe;
    cpu    = (m.mode == M_CPU);
    strobe = cpu && (m.k > S) && (m.k <= S + STR + m.ext);
    check("addr_oe",  bif.addr_oe,  cpu);
    check("data_oe",  bif.data_oe,  cpu && m.wr);
    check("rd",       bif.rd,       strobe && !m.wr);
    check("wr",       bif.wr,       strobe && m.wr);
    check("cpu_ack",  bif.cpu_ack,  m.ack);
    check("bus_err",  bif.bus_err,  m.err);
    check("cpu_rdata", bif.cpu_rdata, m.rdata);
    check("dma_ack",  bif.dma_ack,  m.mode == M_DMA);
    check("halt",     bif.halt,     (m.mode == M_HALT) || (m.mode == M_DMA && m.ret_halt));
    check("bus_busy", bif.bus_busy, m.mode != M_IDLE);
    if (cpu) begin
      check("address_bus", bif.address_bus, m.addr);
      check("mem_io",      bif.mem_io,      m.mio);
      check("data_bus_out", bif.data_bus_out, m.wdata);
    end
  endtask

  always @(negedge clk) if (chk_en) compare_all();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_fields();
    bif.cpu_wr     = 1'($urandom_range(0, 1));
    bif.cpu_mem_io = 1'($urandom_range(0, 1));
    bif.cpu_addr   = 22'($urandom);
    bif.cpu_wdata  = 8'($urandom);
  endtask

  initial begin
    bif.cpu_req = 0; bif.cpu_wr = 0; bif.cpu_mem_io = 0; bif.cpu_addr = '0; bif.cpu_wdata = '0;
    bif.halt_req = 0; bif.wake = 0; bif.dma_req = 0; bif.pin_wait = 0; bif.data_bus_in = '0;

    // reset state
    tick();
    check("rst_cpu_ack", bif.cpu_ack, 0);
    check("rst_rd_wr", {bif.rd, bif.wr}, 0);
    check("rst_oe", {bif.addr_oe, bif.data_oe}, 0);
    check("rst_halt_dma", {bif.halt, bif.dma_ack, bif.bus_busy, bif.bus_err, bif.mem_io}, 0);
    check("rst_address_bus", bif.address_bus, 0);
    check("rst_data_bus_out", bif.data_bus_out, 0);
    check("rst_cpu_rdata", bif.cpu_rdata, 0);
    arst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();

    // read, default timing
    bif.cpu_req = 1; bif.cpu_wr = 0; bif.cpu_addr = 22'h012345; bif.cpu_mem_io = 1;
    bif.data_bus_in = 8'hA5;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("rd_rd", bif.rd, (c == 2 || c == 3));
      check("rd_ack", bif.cpu_ack, (c == 5));
      check("rd_addr_oe", bif.addr_oe, (c <= 4));
      if (c <= 4) check("rd_address", bif.address_bus, 22'h012345);
      if (c == 1) check("rd_mem_io", bif.mem_io, 1);
      if (c == 5) check("rd_rdata", bif.cpu_rdata, 8'hA5);
      if (c == 5) bif.cpu_req = 0;
    end
    repeat (2) tick();

    // write stretched by three sampled pin_wait cycles
    bif.cpu_req = 1; bif.cpu_wr = 1; bif.cpu_wdata = 8'h3C; bif.cpu_addr = 22'h2AAAAA;
    bif.cpu_mem_io = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("wr_wr", bif.wr, (c >= 2 && c <= 6));
      check("wr_data_oe", bif.data_oe, (c <= 7));
      check("wr_ack", bif.cpu_ack, (c == 8));
      check("wr_rd", bif.rd, 0);
      if (c <= 7) check("wr_data_bus_out", bif.data_bus_out, 8'h3C);
      bif.pin_wait = (c >= 3 && c <= 5);
      if (c == 8) bif.cpu_req = 0;
    end
    repeat (2) tick();

    // DMA request raised mid-strobe waits for the CPU cycle to finish
    bif.cpu_req = 1; bif.cpu_wr = 0; bif.cpu_addr = 22'h000ABC; bif.data_bus_in = 8'h5A;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("dma_ack", bif.dma_ack, (c == 6 || c == 7));
      check("dma_cpu_ack", bif.cpu_ack, (c == 5));
      if (c == 6 || c == 7) check("dma_addr_oe", bif.addr_oe, 0);
      bif.dma_req = (c >= 2 && c <= 6);
      if (c == 5) bif.cpu_req = 0;
    end
    repeat (2) tick();

    // halt, DMA from halt, wake
    bif.halt_req = 1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bif.halt_req = 0;
      check("hlt_halt", bif.halt, (c <= 3));
      check("hlt_dma_ack", bif.dma_ack, (c == 2));
      check("hlt_busy", bif.bus_busy, (c <= 3));
      bif.dma_req = (c == 1);
      bif.wake    = (c == 3);
    end
    bif.wake = 0;
    repeat (2) tick();

    // asynchronous reset in the middle of a strobe
    bif.cpu_req = 1; bif.cpu_wr = 0; bif.cpu_addr = 22'h3FFFFF;
    tick();
    tick();
    check("arst_pre_rd", bif.rd, 1);
    #1 arst_n = 1'b0;
    #1;
    check("arst_rd", bif.rd, 0);
    check("arst_addr_oe", bif.addr_oe, 0);
    check("arst_busy", bif.bus_busy, 0);
    bif.cpu_req = 0;
    #3 arst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("arst_no_ack", bif.cpu_ack, 0);
      check("arst_idle", bif.bus_busy, 0);
    end

`ifdef BUS_WAIT_TIMEOUT_EN
    // pin_wait stuck high on a read aborts after WT extensions
    bif.cpu_req = 1; bif.cpu_wr = 0; bif.cpu_addr = 22'h000111; bif.pin_wait = 1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("to_rd", bif.rd, (c >= 2 && c <= 7));
      check("to_ack", bif.cpu_ack, (c == 8));
      check("to_err", bif.bus_err, (c == 8));
      if (c == 8) begin
        check("to_rdata", bif.cpu_rdata, 8'hFF);
        bif.cpu_req = 0; bif.pin_wait = 0;
      end
    end
    repeat (2) tick();
`endif

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (bif.cpu_ack) n_acks++;
      if (bif.cpu_req) begin
        if (bif.cpu_ack) begin
          if ($urandom_range(0, 1) == 0) bif.cpu_req = 0;
          else new_fields();
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bif.cpu_req = 1;
        new_fields();
      end
      if (bif.dma_req) bif.dma_req = ($urandom_range(0, 3) != 0);
      else             bif.dma_req = ($urandom_range(0, 29) == 0);
      bif.halt_req    = ($urandom_range(0, 39) == 0);
      bif.wake        = ($urandom_range(0, 7) == 0);
      bif.pin_wait    = ($urandom_range(0, 2) == 0);
      bif.data_bus_in = 8'($urandom);
    end
    check("rand_progress", (n_acks > 20), 1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
